// File: rtl/vc_arbiter_rr_pkg.sv
// Shared constants, FSM encoding and one-hot helpers for the virtual-channel round-robin arbiter.
package vc_arbiter_rr_pkg;

  localparam int unsigned DATA_BITS = 10;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CLASS_MSB = DATA_BITS - 1;
  localparam int unsigned CLASS_LSB = DATA_BITS - 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArb   = 2'd1,
    StPause = 2'd2
  } arb_state_e;

  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] idx_to_onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/vc_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or above ptr_i, modulo 4.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o,
  output logic       valid_o
);

  logic [1:0] idx;

  always_comb begin
    grant_o = 4'b0000;
    valid_o = 1'b0;
    idx     = ptr_i;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_i + 2'(i);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_arbiter_rr.sv
// Round-robin pop from four input FIFOs, routing each word to the output FIFO named by its class.
module vc_arbiter_rr
  import vc_arbiter_rr_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           in_empty,
  input  logic [NUM_CH*DATA_BITS-1:0] in_data,
  output logic [NUM_CH-1:0]           in_pop,
  input  logic [NUM_CH-1:0]           out_almost_full,
  input  logic [NUM_CH-1:0]           out_full,
  output logic [NUM_CH-1:0]           out_push,
  output logic [DATA_BITS-1:0]        out_data,
  output logic                        active,
  output logic                        error_out
);

  arb_state_e           state_q, state_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  // [0]: a pop was issued last cycle; [1]: out_data_q holds a word to push
  logic [1:0]           pop_vld_q;
  logic [1:0]           pop_sel_q;
  logic [DATA_BITS-1:0] out_data_q;
  logic [DATA_BITS-1:0] sel_word;
  logic                 error_q;
  logic [3:0]           grant;
  logic                 grant_vld;
  logic                 any_req;
  logic                 af_any;

  assign any_req = ~&in_empty;
  assign af_any  = |out_almost_full;

  rr_pick4 u_pick (
    .req_i   (~in_empty),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    in_pop   = '0;
    case (state_q)
      StIdle: begin
        if (any_req && !af_any) state_d = StArb;
      end
      StArb: begin
        // Almost-full wins over a pending grant so no extra word is put in flight.
        if (af_any) begin
          state_d = StPause;
        end else if (!grant_vld) begin
          state_d = StIdle;
        end else if (!reset) begin
          in_pop   = grant;
          rr_ptr_d = onehot4_to_idx(grant) + 2'd1;
        end
      end
      StPause: begin
        if (!af_any) state_d = any_req ? StArb : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_word = in_data[DATA_BITS-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop_sel_q == 2'(i)) sel_word = in_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 2'd0;
      pop_vld_q  <= 2'b00;
      pop_sel_q  <= 2'd0;
      out_data_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      pop_vld_q <= {pop_vld_q[0], |in_pop};
      if (|in_pop) pop_sel_q <= onehot4_to_idx(in_pop);
      if (pop_vld_q[0]) out_data_q <= sel_word;
      if (|(out_push & out_full)) error_q <= 1'b1;
    end
  end

  assign out_push  = pop_vld_q[1] ? idx_to_onehot4(out_data_q[CLASS_MSB:CLASS_LSB]) : '0;
  assign out_data  = out_data_q;
  assign active    = (state_q == StArb);
  assign error_out = error_q;

endmodule

// File: tb/tb_vc_arbiter_rr.sv
// Directed bench: FIFO models feed the arbiter, a scoreboard queue is checked by a push monitor.
module tb_vc_arbiter_rr;
  import vc_arbiter_rr_pkg::*;

  logic                        clk;
  logic                        reset;
  logic [NUM_CH-1:0]           in_empty;
  logic [NUM_CH*DATA_BITS-1:0] in_data;
  logic [NUM_CH-1:0]           in_pop;
  logic [NUM_CH-1:0]           out_almost_full;
  logic [NUM_CH-1:0]           out_full;
  logic [NUM_CH-1:0]           out_push;
  logic [DATA_BITS-1:0]        out_data;
  logic                        active;
  logic                        error_out;

  typedef struct {
    logic [DATA_BITS-1:0] w;
    int                   due;
  } exp_t;
  typedef logic [DATA_BITS-1:0] wq_t [$];

  exp_t       exp_q [$];
  wq_t        fifo [4];
  logic [3:0] exp_pop [$];
  int         nchk = 0;
  int         nfail = 0;
  int         cyc = 0;
  int         push_cnt = 0;

  vc_arbiter_rr dut (
    .clk             (clk),
    .reset           (reset),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .in_pop          (in_pop),
    .out_almost_full (out_almost_full),
    .out_full        (out_full),
    .out_push        (out_push),
    .out_data        (out_data),
    .active          (active),
    .error_out       (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int ch, input logic [DATA_BITS-1:0] w);
    fifo[ch].push_back(w);
    in_empty[ch] = 1'b0;
  endtask

  // Sample the pop mid-cycle, then model the FIFO read data appearing just after the edge.
  task automatic step(output logic [3:0] pop_s);
    int                   pc;
    logic [DATA_BITS-1:0] w;
    exp_t                 e;
    @(negedge clk);
    pop_s = in_pop;
    pc    = cyc;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_s[i]) begin
        nchk++;
        if (fifo[i].size() == 0) begin
          nfail++;
          $display("FAIL pop_of_empty: ch%0d popped with 0 words, required no pop", i);
        end else begin
          w     = fifo[i].pop_front();
          e.w   = w;
          e.due = pc + 2;
          exp_q.push_back(e);
          in_data[i*DATA_BITS +: DATA_BITS] = w;
          in_empty[i] = (fifo[i].size() == 0);
        end
      end
    end
  endtask

  task automatic run_pops(input string name);
    logic [3:0] p;
    while (exp_pop.size() != 0) begin
      step(p);
      chk(name, 32'(p), 32'(exp_pop.pop_front()));
    end
  endtask

  task automatic drain();
    logic [3:0] p;
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) step(p);
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  // Monitor: every push must match the oldest outstanding word, at pop cycle + 2.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        nchk++;
        nfail++;
        $display("FAIL missing_push: word %0h due cycle %0d, none by cycle %0d",
                 exp_q[0].w, exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
      if (out_push != 4'b0000) begin
        push_cnt++;
        if (exp_q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL spurious_push: out_push=%b data=%0h, required no push", out_push, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("push_data", 32'(out_data), 32'(e.w));
          chk("push_vec", 32'(out_push), 32'(4'b0001 << e.w[DATA_BITS-1:DATA_BITS-2]));
          chk("push_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] p;
    int         base;
    reset           = 1'b1;
    in_empty        = 4'b1111;
    in_data         = '0;
    out_almost_full = 4'b0000;
    out_full        = 4'b0000;

    // Reset with every FIFO holding three words; nothing may move.
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 3; k++) load(ch, {2'(ch + k), 8'(8'h10 * ch + k)});
    end
    repeat (2) begin
      step(p);
      chk("rst_pop", 32'(p), 0);
      chk("rst_push", 32'(out_push), 0);
      chk("rst_err", 32'(error_out), 0);
      chk("rst_active", 32'(active), 0);
    end
    reset = 1'b0;

    // Full round-robin over four busy channels, one pop per cycle.
    exp_pop = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8,
                4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    run_pops("rr_order");
    drain();

    // Single word on channel 2, class 2.
    load(2, 10'h2A5);
    exp_pop = '{4'h0, 4'h4, 4'h0};
    run_pops("single_ch2");
    drain();

    // Pointer now 3: channels 0 and 3 alternate starting from 3.
    load(0, 10'h005);
    load(0, 10'h106);
    load(3, 10'h3F0);
    load(3, 10'h2F1);
    exp_pop = '{4'h0, 4'h8, 4'h1, 4'h8, 4'h1, 4'h0};
    run_pops("ptr_wrap");
    drain();

    // Almost-full back-pressure in the middle of steady traffic.
    for (int k = 0; k < 4; k++) begin
      load(0, {2'(k), 8'(8'h40 + k)});
      load(1, {2'(k + 1), 8'(8'h50 + k)});
    end
    exp_pop = '{4'h0, 4'h2, 4'h1, 4'h2};
    run_pops("af_pre");
    out_almost_full = 4'b0010;
    base = push_cnt;
    exp_pop = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_pops("af_hold");
    chk("af_state", 32'(dut.state_q), 32'(StPause));
    chk("af_active", 32'(active), 0);
    chk("af_inflight_pushes", push_cnt - base, 2);
    out_almost_full = 4'b0000;
    exp_pop = '{4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h0};
    run_pops("af_resume");
    drain();

    // Class-3 word pushed while output FIFO 3 is full.
    out_full = 4'b1000;
    load(1, 10'h3C1);
    exp_pop = '{4'h0, 4'h2, 4'h0};
    run_pops("err_pop");
    chk("err_before_push", 32'(error_out), 0);
    step(p);
    chk("err_set", 32'(error_out), 1);
    out_full = 4'b0000;
    load(2, 10'h011);
    exp_pop = '{4'h0, 4'h4, 4'h0};
    run_pops("err_traffic");
    drain();
    chk("err_sticky", 32'(error_out), 1);

    reset = 1'b1;
    step(p);
    chk("rst2_err", 32'(error_out), 0);
    chk("rst2_active", 32'(active), 0);
    reset = 1'b0;
    step(p);
    chk("rst2_push", 32'(out_push), 0);
    chk("rst2_pop", 32'(p), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
